// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the EX-stage control and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  ex_no_op;
    logic                  flush;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, ex_no_op, flush, op, operand_a, operand_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, ex_no_op, flush, op, operand_a, operand_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// Multiplies by shift-add, divides by restoring division on operand magnitudes,
// then applies sign correction in a single FIX cycle.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input logic             clk,
    input logic             rst_n,
    mult_div_unit_if.slave  bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [2*W-1:0]         acc_q;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [W-1:0]           opb_q;       // multiplicand (mul) or divisor (div) magnitude
    logic [W-1:0]           raw_a_q;     // unmodified dividend, returned on divide by zero
    logic                   is_div_q;
    logic                   neg_res_q;   // product / quotient must be negated
    logic                   neg_rem_q;   // remainder takes the dividend's sign
    logic                   div_zero_q;
    logic [W-1:0]           hi_q, lo_q;
    logic                   done_q;

    logic                   accept;
    logic                   accept_iter;
    logic                   last_iter;
    logic                   op_signed;
    logic                   op_div;
    logic [W-1:0]           mag_a, mag_b;
    logic [W:0]             mul_sum;
    logic [W:0]             rem_shift;
    logic [W:0]             div_diff;
    logic [2*W-1:0]         acc_iter;
    logic [2*W-1:0]         prod_fix;
    logic [W-1:0]           res_hi, res_lo;

    assign accept      = (state_q == IDLE) && bus.start && !bus.ex_no_op && !bus.flush
                         && (bus.op <= 3'd5);
    assign accept_iter = accept && (bus.op <= 3'd3);
    assign last_iter   = (cnt_q == CNT_WIDTH'(W - 1));
    assign op_signed   = ~bus.op[0];
    assign op_div      = bus.op[1];
    assign mag_a       = (op_signed && bus.operand_a[W-1]) ? -bus.operand_a : bus.operand_a;
    assign mag_b       = (op_signed && bus.operand_b[W-1]) ? -bus.operand_b : bus.operand_b;

    // One radix-2 step of the selected algorithm, plus the sign-corrected result for FIX.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opb_q : {W{1'b0}})};
        rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = rem_shift - {1'b0, opb_q};
        acc_iter  = {mul_sum, acc_q[W-1:1]};
        if (is_div_q) begin
            if (!div_diff[W]) begin
                acc_iter = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_iter = {rem_shift[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end

        prod_fix = neg_res_q ? -acc_q : acc_q;
        res_hi   = prod_fix[2*W-1:W];
        res_lo   = prod_fix[W-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                res_hi = raw_a_q;
                res_lo = {W{1'b1}};
            end else begin
                res_hi = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                res_lo = neg_res_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush aborts any iterative operation back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_iter) state_d = RUN;
            RUN: begin
                if (bus.flush)      state_d = IDLE;
                else if (last_iter) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO writes and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            raw_a_q    <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == FIX) && !bus.flush;
            if (accept && bus.op == 3'd4) hi_q <= bus.operand_a;
            if (accept && bus.op == 3'd5) lo_q <= bus.operand_a;
            if (accept_iter) begin
                cnt_q      <= '0;
                acc_q      <= {{W{1'b0}}, (op_div ? mag_a : mag_b)};
                opb_q      <= op_div ? mag_b : mag_a;
                raw_a_q    <= bus.operand_a;
                is_div_q   <= op_div;
                neg_res_q  <= op_signed && (bus.operand_a[W-1] ^ bus.operand_b[W-1]);
                neg_rem_q  <= op_signed && bus.operand_a[W-1];
                div_zero_q <= (bus.operand_b == '0);
            end
            if (state_q == RUN && !bus.flush) begin
                acc_q <= acc_iter;
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == FIX && !bus.flush) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID-stage register file. It consumes the rs/rt operands (`read_data_1`/`read_data_2`) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the architectural HI/LO registers. While an iterative operation runs, it raises `busy` so the hazard logic stalls the pipeline.

## Interface
- `DATA_WIDTH`, default 32 (`ISA_WIDTH`): operand and HI/LO width.
- `CNT_WIDTH`, default 5: iteration counter width; must satisfy 2^CNT_WIDTH == DATA_WIDTH.

- `clk`  input  1  system clock, rising-edge active.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  EX instruction is a HI/LO-writing op.
- `ex_no_op`  input  1  EX slot holds a bubble; `start` is ignored.
- `flush`  input  1  synchronous abort of any in-flight operation.
- `op`  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved (ignored).
- `operand_a`  input  DATA_WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source).
- `operand_b`  input  DATA_WIDTH  rt value (multiplier / divisor).
- `busy`  output  1  operation in flight; pipeline must stall.
- `done`  output  1  one-cycle pulse when HI/LO receive an iterative result.
- `hi`  output  DATA_WIDTH  HI register.
- `lo`  output  DATA_WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- Accept condition: state IDLE, `start` = 1, `ex_no_op` = 0, `flush` = 0, and op ≤ 5.
- MTHI/MTLO: on the accepting edge, `hi` (or `lo`) <= `operand_a`. State stays IDLE. No `busy`, no `done`.
- MULT/MULTU/DIV/DIVU: on the accepting edge, latch the operand magnitudes and sign flags, clear the counter, and enter RUN.
  - Magnitudes use abs() for signed ops, raw values for unsigned ops.
- RUN: one radix-2 iteration per cycle; the counter increments each cycle. After the iteration with count = DATA_WIDTH-1, go to FIX.
  - Multiply: shift-add into a 2*DATA_WIDTH-bit accumulator.
  - Divide: restoring divide, producing a DATA_WIDTH-bit quotient and remainder.
- FIX: apply sign correction, write `hi`/`lo`, assert `done` for the following cycle, return to IDLE.
  - Multiply: negate the 64-bit product if signed and the operand signs differ. `hi` = upper word, `lo` = lower word.
  - Divide: `lo` = quotient, negated if signed and signs differ. `hi` = remainder, carrying the dividend's sign.
- Divide by zero (`operand_b` = 0, DIV or DIVU): `lo` = all ones and `hi` = `operand_a` unchanged. No sign correction is applied.
- Signed overflow (0x80000000 / 0xFFFFFFFF): `lo` = 0x80000000, `hi` = 0.
- `start` while RUN or FIX is ignored. Upstream must hold the instruction under `busy`.
- `flush` in RUN or FIX: next state IDLE, `hi`/`lo` unchanged, no `done`.
- `flush` with `start` in IDLE: flush wins, nothing is accepted.
- Reserved op: ignored, state unchanged.
- `busy` = (state != IDLE), decoded from registered state only.

## Timing
- Reset (async, `rst_n` = 0): state IDLE, counter 0, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, internal accumulators 0.
  - Reset mid-operation discards the result immediately.
- Let the accepting rising edge be edge 0.
  - `busy` = 1 from after edge 0 through edge 33.
  - RUN spans edges 1-32; FIX is entered after edge 32.
  - `hi`/`lo` update and `done` = 1 after edge 33.
  - `done` returns to 0 after edge 34 unless a new op has completed.
- Latency: 34 edges (accept + 32 iterations + fix); `busy` is high for 33 cycles.
- MTHI/MTLO latency: the value is visible on `hi`/`lo` the cycle after edge 0.
- A new op may be accepted on the same edge that `busy` falls, i.e. the edge after FIX.

## Test plan
- Reset: assert `rst_n` = 0 mid-RUN -> immediately `busy` = 0, `hi` = `lo` = 0, `done` = 0; after release, `start` MTLO 0x12345678 -> `lo` = 0x12345678 next cycle, `busy` stays 0.
- MULT 0xFFFFFFFD × 0x00000005 -> `busy` for 33 cycles, then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1, single-cycle `done`.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi` = 0xFFFFFFFE, `lo` = 0x00000001 after 34 edges.
- DIV 0xFFFFFFF9 / 0x00000002 -> `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> `lo` = 0x80000000, `hi` = 0.
- DIVU 0x00000064 / 0 -> `lo` = 0xFFFFFFFF, `hi` = 0x00000064. Second `start` during `busy` is ignored; the result is unaffected.
- Prime `hi` = 0xAAAA0000; start MULT; `flush` at edge 10 -> `busy` = 0 next cycle, `hi` still 0xAAAA0000, no `done`. `start` with `ex_no_op` = 1 -> no state change.
